wdt_multi: RTL and testbench

Parametrised multi-channel watchdog timer for the RV32IF SoC. All channels share one programmable prescaler and are each programmed through a simple register-write port; an AXI slave wrapper drives that port. Each channel raises an early-warning interrupt and a sticky timeout. A registered reset request, the OR of all timeouts, is fed to the system reset logic. Compared with the single-channel WDT it adds channel count, counter width, warning level, a lock bit and an optional window mode.

---
 rtl/wdt_pkg.sv | 30 +++
 rtl/wdt_channel.sv | 115 +++++++++++
 rtl/wdt_multi.sv | 94 +++++++++
 tb/tb_wdt_multi.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared definitions for the multi-channel watchdog: register map, CTRL bits,
// default kick key and the per-channel write-strobe bundle.
package wdt_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_TIMEOUT  = 2'd1;
    localparam logic [1:0] REG_KICK     = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOCK_BIT = 1;

    localparam logic [15:0] DEF_KICK_KEY = 16'hA5C3;

    typedef struct packed {
        logic ctrl;
        logic timeout;
        logic kick;
    } wr_strb_t;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int sel_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: counter, timeout, enable/lock, sticky warning and timeout.
// Window-mode kick checking is compiled in when WDT_WINDOW_EN is defined.
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter int          WARN     = 16,
    parameter logic [15:0] KICK_KEY = DEF_KICK_KEY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  wr_strb_t         wr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] cnt,
    output logic             pre_irq,
    output logic             wto
);

    localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN);

    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_step_s, inc_s, to_r, to_nxt_s;
    logic             en_r, en_nxt_s, lock_r, lock_nxt_s;
    logic             pre_r, pre_nxt_s, pre_step_s;
    logic             wto_r, wto_nxt_s, wto_step_s;
    logic             fire_s, warn_hit_s, kick_ok_s;

    // Counting step on a tick; a lowered timeout already at or below cnt fires too.
    always_comb begin
        inc_s      = cnt_r + CNT_W'(1);
        fire_s     = (inc_s == to_r) || (cnt_r >= to_r);
        warn_hit_s = (to_r > WARN_C) && (inc_s == (to_r - WARN_C));
        cnt_step_s = cnt_r;
        pre_step_s = pre_r;
        wto_step_s = wto_r;
        if (en_r && !wto_r && tick) begin
            if (fire_s) begin
                wto_step_s = 1'b1;
                cnt_step_s = (inc_s == to_r) ? inc_s : cnt_r;
            end else begin
                cnt_step_s = inc_s;
            end
            if (warn_hit_s) begin
                pre_step_s = 1'b1;
            end else begin
                pre_step_s = pre_r;
            end
        end else begin
            cnt_step_s = cnt_r;
        end
    end

    // Register writes layered over the counting step; writes are mutually exclusive.
    always_comb begin
        kick_ok_s  = wr.kick && (wdata[15:0] == KICK_KEY) && !wto_r;
        cnt_nxt_s  = cnt_step_s;
        pre_nxt_s  = pre_step_s;
        wto_nxt_s  = wto_step_s;
        to_nxt_s   = to_r;
        en_nxt_s   = en_r;
        lock_nxt_s = lock_r;
        if (wr.ctrl && !lock_r) begin
            en_nxt_s   = wdata[CTRL_EN_BIT];
            lock_nxt_s = wdata[CTRL_LOCK_BIT];
            if (wdata[CTRL_EN_BIT]) begin
                cnt_nxt_s = cnt_step_s;
            end else begin
                cnt_nxt_s = '0;
                pre_nxt_s = 1'b0;
                wto_nxt_s = 1'b0;
            end
        end else if (wr.timeout && !lock_r) begin
            to_nxt_s = wdata;
        end else if (kick_ok_s) begin
`ifdef WDT_WINDOW_EN
            if (cnt_r < (to_r >> 2'd2)) begin
                wto_nxt_s = 1'b1;
                cnt_nxt_s = cnt_r;
            end else begin
                cnt_nxt_s = '0;
                pre_nxt_s = 1'b0;
            end
`else
            cnt_nxt_s = '0;
            pre_nxt_s = 1'b0;
`endif
        end else begin
            cnt_nxt_s = cnt_step_s;
        end
    end

    // Channel state registers; timeout resets to all ones so nothing fires early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            to_r   <= '1;
            en_r   <= 1'b0;
            lock_r <= 1'b0;
            pre_r  <= 1'b0;
            wto_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            to_r   <= to_nxt_s;
            en_r   <= en_nxt_s;
            lock_r <= lock_nxt_s;
            pre_r  <= pre_nxt_s;
            wto_r  <= wto_nxt_s;
        end
    end

    assign cnt     = cnt_r;
    assign pre_irq = pre_r;
    assign wto     = wto_r;

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog top: shared prescaler, write decode, count readback
// mux and reset request. Optional window mode is selected by WDT_WINDOW_EN.
module wdt_multi
    import wdt_pkg::*;
#(
    parameter int          N_CH     = 2,
    parameter int          CNT_W    = 32,
    parameter int          PRE_W    = 8,
    parameter int          WARN     = 16,
    parameter logic [15:0] KICK_KEY = DEF_KICK_KEY,
    localparam int         SEL_W    = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [SEL_W-1:0] wsel,
    input  logic [1:0]       waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [SEL_W-1:0] rsel,
    output logic [CNT_W-1:0] rcnt,
    output logic [N_CH-1:0]  pre_irq,
    output logic [N_CH-1:0]  wto,
    output logic             rst_req
);

    logic [PRE_W-1:0] presc_r, pre_cnt_r;
    logic             tick_s, presc_wr_s, rst_req_r;
    wr_strb_t         strb_s [N_CH];
    logic [CNT_W-1:0] cnt_s  [N_CH];

    assign tick_s     = (pre_cnt_r == presc_r);
    assign presc_wr_s = wen && (waddr == REG_PRESCALE);

    // Shared prescaler; a PRESCALE write restarts the divider phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r   <= '0;
            pre_cnt_r <= '0;
        end else if (presc_wr_s) begin
            presc_r   <= wdata[PRE_W-1:0];
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    // Per-channel strobes; selects at or beyond N_CH match no channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            strb_s[i].ctrl    = wen && (wsel == SEL_W'(i)) && (waddr == REG_CTRL);
            strb_s[i].timeout = wen && (wsel == SEL_W'(i)) && (waddr == REG_TIMEOUT);
            strb_s[i].kick    = wen && (wsel == SEL_W'(i)) && (waddr == REG_KICK);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        wdt_channel #(
            .CNT_W    (CNT_W),
            .WARN     (WARN),
            .KICK_KEY (KICK_KEY)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick_s),
            .wr      (strb_s[g]),
            .wdata   (wdata),
            .cnt     (cnt_s[g]),
            .pre_irq (pre_irq[g]),
            .wto     (wto[g])
        );
    end

    // Count readback; unmatched selects read as zero.
    always_comb begin
        rcnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            rcnt = (rsel == SEL_W'(i)) ? cnt_s[i] : rcnt;
        end
    end

    // Reset request follows any timeout by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_req_r <= 1'b0;
        end else begin
            rst_req_r <= |wto;
        end
    end

    assign rst_req = rst_req_r;

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi (N_CH=2, presc default 0, WARN=16, key A5C3).
module tb_wdt_multi;
    import wdt_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [0:0]  wsel = 1'b0;
    logic [1:0]  waddr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [0:0]  rsel = 1'b0;
    logic [31:0] rcnt;
    logic [1:0]  pre_irq, wto;
    logic        rst_req;
    int          total = 0;
    int          bad = 0;

    wdt_multi dut (
        .clk(clk), .rst(rst), .wen(wen), .wsel(wsel), .waddr(waddr),
        .wdata(wdata), .rsel(rsel), .rcnt(rcnt), .pre_irq(pre_irq),
        .wto(wto), .rst_req(rst_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
    task automatic wr(input logic [0:0] sel, input logic [1:0] addr, input logic [31:0] data);
        wsel  = sel;
        waddr = addr;
        wdata = data;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_wto", {30'd0, wto}, 32'd0);
        check("rst_pre", {30'd0, pre_irq}, 32'd0);
        check("rst_req", {31'd0, rst_req}, 32'd0);
        check("rst_rcnt", rcnt, 32'd0);
        rst = 1'b0;

        // basic timeout on ch0, TO=20
        rsel = 1'b0;
        wr(1'b0, REG_TIMEOUT, 32'd20);
        wr(1'b0, REG_CTRL, 32'd1);
        check("t1_cnt0", rcnt, 32'd0);
        idle(3);
        check("t1_cnt3", rcnt, 32'd3);
        check("t1_pre_lo", {31'd0, pre_irq[0]}, 32'd0);
        idle(1);
        check("t1_pre_hi", {31'd0, pre_irq[0]}, 32'd1);
        check("t1_cnt4", rcnt, 32'd4);
        idle(15);
        check("t1_cnt19", rcnt, 32'd19);
        check("t1_wto_lo", {31'd0, wto[0]}, 32'd0);
        idle(1);
        check("t1_wto_hi", {31'd0, wto[0]}, 32'd1);
        check("t1_req_lo", {31'd0, rst_req}, 32'd0);
        idle(1);
        check("t1_req_hi", {31'd0, rst_req}, 32'd1);
        check("t1_cnt_hold", rcnt, 32'd20);
        wr(1'b0, REG_CTRL, 32'd0);
        check("t1_clr_wto", {31'd0, wto[0]}, 32'd0);
        check("t1_clr_pre", {31'd0, pre_irq[0]}, 32'd0);
        check("t1_clr_cnt", rcnt, 32'd0);
        idle(1);
        check("t1_clr_req", {31'd0, rst_req}, 32'd0);

        // lowering TO below the current count fires on the next tick
        wr(1'b0, REG_CTRL, 32'd1);
        idle(10);
        wr(1'b0, REG_TIMEOUT, 32'd5);
        check("lo_cnt11", rcnt, 32'd11);
        check("lo_wto_lo", {31'd0, wto[0]}, 32'd0);
        idle(1);
        check("lo_wto_hi", {31'd0, wto[0]}, 32'd1);
        check("lo_cnt_hold", rcnt, 32'd11);
        wr(1'b0, REG_CTRL, 32'd0);

        // prescaler 3, TO=5: enable lands on a tick edge so wto is 20 cycles later
        wr(1'b0, REG_PRESCALE, 32'd3);
        idle(3);
        wr(1'b0, REG_CTRL, 32'd1);
        idle(19);
        check("t2_cnt4", rcnt, 32'd4);
        check("t2_wto_lo", {31'd0, wto[0]}, 32'd0);
        idle(1);
        check("t2_wto_hi", {31'd0, wto[0]}, 32'd1);
        check("t2_no_pre", {31'd0, pre_irq[0]}, 32'd0);
        wr(1'b0, REG_PRESCALE, 32'd0);
        wr(1'b0, REG_CTRL, 32'd0);

        // TO=0 fires on the first tick after enable
        wr(1'b1, REG_TIMEOUT, 32'd0);
        wr(1'b1, REG_CTRL, 32'd1);
        check("to0_lo", {31'd0, wto[1]}, 32'd0);
        idle(1);
        check("to0_hi", {31'd0, wto[1]}, 32'd1);
        wr(1'b1, REG_CTRL, 32'd0);

        // early keyed kick at cnt=5 with TO=40
        wr(1'b0, REG_TIMEOUT, 32'd40);
        wr(1'b0, REG_CTRL, 32'd1);
        idle(5);
        wr(1'b0, REG_KICK, 32'h0000A5C3);
`ifdef WDT_WINDOW_EN
        check("win_wto", {31'd0, wto[0]}, 32'd1);
        check("win_hold", rcnt, 32'd5);
        wr(1'b0, REG_CTRL, 32'd0);
        wr(1'b0, REG_CTRL, 32'd1);
        idle(12);
        wr(1'b0, REG_KICK, 32'h0000A5C3);
        check("win_ok_cnt", rcnt, 32'd0);
        check("win_ok_wto", {31'd0, wto[0]}, 32'd0);
`else
        check("early_kick_cnt", rcnt, 32'd0);
        check("early_kick_wto", {31'd0, wto[0]}, 32'd0);
`endif
        wr(1'b0, REG_CTRL, 32'd0);

        // periodic kicks on ch1, TO=20
        rsel = 1'b1;
        wr(1'b1, REG_TIMEOUT, 32'd20);
        wr(1'b1, REG_CTRL, 32'd1);
        for (int k = 0; k < 3; k++) begin
            idle(9);
            check("k_pre_set", {31'd0, pre_irq[1]}, 32'd1);
            wr(1'b1, REG_KICK, 32'h0000A5C3);
            check("k_cnt", rcnt, 32'd0);
            check("k_pre_clr", {31'd0, pre_irq[1]}, 32'd0);
            check("k_wto", {31'd0, wto[1]}, 32'd0);
        end
        idle(2);
        wr(1'b1, REG_KICK, 32'h00001234);
        check("k_badkey", rcnt, 32'd3);
        idle(16);
        check("k_cnt19", rcnt, 32'd19);
        check("k_wto_lo", {31'd0, wto[1]}, 32'd0);
        idle(1);
        check("k_wto_hi", {31'd0, wto[1]}, 32'd1);
        wr(1'b1, REG_KICK, 32'h0000A5C3);
        check("k_after_wto_cnt", rcnt, 32'd20);
        check("k_after_wto", {31'd0, wto[1]}, 32'd1);

        // reset mid-run: ch0 at 17, ch1 timed out
        rsel = 1'b0;
        wr(1'b0, REG_TIMEOUT, 32'd100);
        wr(1'b0, REG_CTRL, 32'd1);
        idle(17);
        check("r_cnt17", rcnt, 32'd17);
        check("r_req_pre", {31'd0, rst_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("r_wto", {30'd0, wto}, 32'd0);
        check("r_pre", {30'd0, pre_irq}, 32'd0);
        check("r_req", {31'd0, rst_req}, 32'd0);
        check("r_rcnt", rcnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wr(1'b0, REG_CTRL, 32'd1);
        idle(5);
        check("r_post_cnt", rcnt, 32'd5);
        check("r_post_wto", {31'd0, wto[0]}, 32'd0);
        wr(1'b0, REG_CTRL, 32'd0);

        // lock blocks CTRL and TIMEOUT writes
        wr(1'b0, REG_TIMEOUT, 32'd30);
        wr(1'b0, REG_CTRL, 32'd3);
        wr(1'b0, REG_CTRL, 32'd0);
        check("l_ctrl_ign", rcnt, 32'd1);
        wr(1'b0, REG_TIMEOUT, 32'd100);
        check("l_cnt2", rcnt, 32'd2);
        idle(27);
        check("l_wto_lo", {31'd0, wto[0]}, 32'd0);
        idle(1);
        check("l_wto_hi", {31'd0, wto[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(1'b0, REG_TIMEOUT, 32'd50);
        wr(1'b0, REG_CTRL, 32'd1);
        idle(3);
        check("l_unl_cnt3", rcnt, 32'd3);
        wr(1'b0, REG_CTRL, 32'd0);
        check("l_unl_clr", rcnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
